// File: rtl/burrito_ctrl.sv
// burrito_ctrl: four-state sequencer that fetches two register operands,
// runs them through an external ALU and writes the result back to the bank.
// One instruction every four cycles; illegal ops complete with an error flag.
//
//   state | meaning
//   IDLE  | waiting for an instruction, instr_ready high
//   READ  | bank read addresses driven, operands captured at the edge
//   EXEC  | ALU operands driven, ALU result captured at the edge
//   WRITE | bank write (unless illegal or protected r0), done pulse
module burrito_ctrl #(
  parameter int PROTECT_R0 = 1,
  parameter int COUNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [2:0]         instr_op,
  input  logic [4:0]         instr_rs,
  input  logic [4:0]         instr_rt,
  input  logic [4:0]         instr_rd,
  output logic [4:0]         rb_read_reg1,
  output logic [4:0]         rb_read_reg2,
  input  logic [31:0]        rb_read_data1,
  input  logic [31:0]        rb_read_data2,
  output logic [4:0]         rb_write_reg,
  output logic [31:0]        rb_write_data,
  output logic               rb_reg_write,
  output logic [31:0]        alu_a,
  output logic [31:0]        alu_b,
  output logic [2:0]         alu_sel,
  input  logic [31:0]        alu_out,
  output logic               done,
  output logic               error,
  output logic [31:0]        result,
  output logic               busy,
  output logic [COUNT_W-1:0] retired_count,
  output logic [COUNT_W-1:0] error_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [4:0]         rs_q, rs_d;
  logic [4:0]         rt_q, rt_d;
  logic [4:0]         rd_q, rd_d;
  logic [31:0]        opa_q, opa_d;
  logic [31:0]        opb_q, opb_d;
  logic [31:0]        res_q, res_d;
  logic [31:0]        result_q, result_d;
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic [COUNT_W-1:0] errcnt_q, errcnt_d;

  logic op_legal;
  logic r0_blocked;

  assign op_legal   = (op_q <= 3'd5);
  assign r0_blocked = (PROTECT_R0 == 1) && (rd_q == 5'd0);

  // Next-state, operand/result capture and counter updates.
  // result and the counters move on the EXEC->WRITE edge so they already
  // show the completed instruction while done is high.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    result_d  = result_q;
    retired_d = retired_q;
    errcnt_d  = errcnt_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          op_d    = instr_op;
          rs_d    = instr_rs;
          rt_d    = instr_rt;
          rd_d    = instr_rd;
          state_d = READ;
        end
      end
      READ: begin
        opa_d   = rb_read_data1;
        opb_d   = rb_read_data2;
        state_d = EXEC;
      end
      EXEC: begin
        res_d = alu_out;
        if (op_legal) begin
          result_d  = alu_out;
          retired_d = retired_q + COUNT_W'(1);
        end else begin
          errcnt_d = errcnt_q + COUNT_W'(1);
        end
        state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      result_q  <= '0;
      retired_q <= '0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      result_q  <= result_d;
      retired_q <= retired_d;
      errcnt_q  <= errcnt_d;
    end
  end

  // Bank/ALU drive: addresses and selects are zero outside their own state.
  always_comb begin
    instr_ready   = (state_q == IDLE);
    busy          = (state_q != IDLE);
    rb_read_reg1  = 5'd0;
    rb_read_reg2  = 5'd0;
    alu_a         = 32'd0;
    alu_b         = 32'd0;
    alu_sel       = 3'd0;
    rb_write_reg  = 5'd0;
    rb_write_data = 32'd0;
    rb_reg_write  = 1'b0;
    done          = 1'b0;
    error         = 1'b0;
    case (state_q)
      READ: begin
        rb_read_reg1 = rs_q;
        rb_read_reg2 = rt_q;
      end
      EXEC: begin
        alu_a   = opa_q;
        alu_b   = opb_q;
        alu_sel = op_q;
      end
      WRITE: begin
        rb_write_reg  = rd_q;
        rb_write_data = res_q;
        rb_reg_write  = op_legal && !r0_blocked;
        done          = 1'b1;
        error         = !op_legal;
      end
      default: begin
      end
    endcase
  end

  assign result        = result_q;
  assign retired_count = retired_q;
  assign error_count   = errcnt_q;

endmodule

// File: tb/tb_burrito_ctrl.sv
// Bench for burrito_ctrl: behavioural register bank and ALU around the DUT,
// directed instruction vectors, and a done-triggered scoreboard monitor.
module tb_burrito_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [4:0]  instr_rs, instr_rt, instr_rd;
  logic [4:0]  rb_read_reg1, rb_read_reg2;
  logic [31:0] rb_read_data1, rb_read_data2;
  logic [4:0]  rb_write_reg;
  logic [31:0] rb_write_data;
  logic        rb_reg_write;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_sel;
  logic [31:0] alu_out;
  logic        done, error, busy;
  logic [31:0] result;
  logic [7:0]  retired_count, error_count;

  burrito_ctrl #(.PROTECT_R0(1), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
    .rb_read_reg1(rb_read_reg1), .rb_read_reg2(rb_read_reg2),
    .rb_read_data1(rb_read_data1), .rb_read_data2(rb_read_data2),
    .rb_write_reg(rb_write_reg), .rb_write_data(rb_write_data), .rb_reg_write(rb_reg_write),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .done(done), .error(error), .result(result), .busy(busy),
    .retired_count(retired_count), .error_count(error_count)
  );

  always #5 clk = ~clk;

  // Register bank model: preset while in reset, written by the DUT otherwise.
  logic [31:0] bank [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) bank[i] <= 32'd0;
      bank[13] <= 32'd5;
      bank[10] <= 32'd3;
      bank[12] <= 32'd2;
      bank[9]  <= 32'd3;
      bank[4]  <= 32'd7;
      bank[5]  <= 32'd3;
      bank[20] <= 32'h0000_F0F0;
      bank[21] <= 32'h0000_0FF0;
    end else if (rb_reg_write) begin
      bank[rb_write_reg] <= rb_write_data;
    end
  end
  assign rb_read_data1 = bank[rb_read_reg1];
  assign rb_read_data2 = bank[rb_read_reg2];

  // ALU model.
  always_comb begin
    alu_out = 32'hDEAD_BEEF;
    case (alu_sel)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = (alu_a > alu_b) ? 32'd1 : 32'd0;
      3'd3: alu_out = alu_a & alu_b;
      3'd4: alu_out = alu_a | alu_b;
      3'd5: alu_out = alu_a ^ alu_b;
      default: alu_out = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] res;
    logic [7:0]  ret;
    logic [7:0]  ecnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [31:0] m_res;
  logic [7:0]  m_ret, m_ecnt;

  int cyc     = 0;
  int acc_cyc = 0;
  logic log_acc = 1'b0;
  int acc_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Cycle counter and accept timestamps.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && instr_valid && instr_ready) begin
      acc_cyc <= cyc;
      if (log_acc) acc_q.push_back(cyc);
    end
  end

  // Monitor: pop one expectation on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (!done) chk("stray_write", 32'(rb_reg_write), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", 32'(cyc - acc_cyc), 32'd3);
          chk("reg_write", 32'(rb_reg_write), 32'(e.we));
          if (e.we) begin
            chk("write_reg", 32'(rb_write_reg), 32'(e.wreg));
            chk("write_data", rb_write_data, e.wdata);
          end
          chk("error", 32'(error), 32'(e.err));
          chk("result", result, e.res);
          chk("retired_count", 32'(retired_count), 32'(e.ret));
          chk("error_count", 32'(error_count), 32'(e.ecnt));
        end
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (!instr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: got busy expected idle within 20 cycles");
    end
  endtask

  function automatic exp_t mk_exp(input logic [2:0] op, input logic [4:0] rd,
                                  input logic we, input logic [31:0] data);
    exp_t e;
    if (op <= 3'd5) begin
      m_res = data;
      m_ret = m_ret + 8'd1;
    end else begin
      m_ecnt = m_ecnt + 8'd1;
    end
    e.we = we; e.wreg = rd; e.wdata = data; e.err = (op > 3'd5);
    e.res = m_res; e.ret = m_ret; e.ecnt = m_ecnt;
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic we, input logic [31:0] data);
    wait_idle();
    sb.push_back(mk_exp(op, rd, we, data));
    instr_op = op; instr_rs = rs; instr_rt = rt; instr_rd = rd;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_op = 3'd0; instr_rs = 5'd0; instr_rt = 5'd0; instr_rd = 5'd0;
    m_res = 32'd0; m_ret = 8'd0; m_ecnt = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_retired", 32'(retired_count), 32'd0);
    chk("rst_errcnt", 32'(error_count), 32'd0);
    chk("rst_sel", 32'(alu_sel), 32'd0);

    issue(3'd0, 5'd13, 5'd10, 5'd8,  1'b1, 32'd8);
    issue(3'd1, 5'd12, 5'd9,  5'd1,  1'b1, 32'hFFFF_FFFF);
    issue(3'd2, 5'd4,  5'd5,  5'd2,  1'b1, 32'd1);
    issue(3'd2, 5'd5,  5'd4,  5'd6,  1'b1, 32'd0);
    issue(3'd3, 5'd20, 5'd21, 5'd3,  1'b1, 32'h0000_00F0);
    issue(3'd4, 5'd20, 5'd21, 5'd11, 1'b1, 32'h0000_FFF0);
    issue(3'd5, 5'd20, 5'd21, 5'd14, 1'b1, 32'h0000_FF00);
    issue(3'd6, 5'd13, 5'd10, 5'd18, 1'b0, 32'd0);
    issue(3'd0, 5'd13, 5'd10, 5'd0,  1'b0, 32'd8);
    issue(3'd7, 5'd13, 5'd10, 5'd5,  1'b0, 32'd0);
    chk("r0_untouched", bank[0], 32'd0);
    chk("r8_written", bank[8], 32'd8);

    // Valid held for 12 edges: expect three accepts four cycles apart.
    for (int k = 0; k < 3; k++) sb.push_back(mk_exp(3'd4, 5'd22, 1'b1, 32'h0000_FFF0));
    log_acc = 1'b1;
    instr_op = 3'd4; instr_rs = 5'd20; instr_rt = 5'd21; instr_rd = 5'd22;
    instr_valid = 1'b1;
    repeat (12) @(posedge clk);
    #1 instr_valid = 1'b0;
    log_acc = 1'b0;
    @(negedge clk);
    wait_idle();
    chk("held_accepts", 32'(acc_q.size()), 32'd3);
    if (acc_q.size() == 3) begin
      chk("held_gap1", 32'(acc_q[1] - acc_q[0]), 32'd4);
      chk("held_gap2", 32'(acc_q[2] - acc_q[1]), 32'd4);
    end

    // Reset while in EXEC: no write, no done, counters/result cleared.
    instr_op = 3'd0; instr_rs = 5'd13; instr_rt = 5'd10; instr_rd = 5'd9;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("exec_sel", 32'(alu_sel), 32'd0);
    chk("exec_a", alu_a, 32'd5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_res = 32'd0; m_ret = 8'd0; m_ecnt = 8'd0;
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_retired", 32'(retired_count), 32'd0);
    chk("abort_result", result, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_r9", bank[9], 32'd3);

    // 256 legal instructions: retired_count wraps back to 0.
    for (int k = 0; k < 256; k++) issue(3'd0, 5'd13, 5'd10, 5'd8, 1'b1, 32'd8);
    chk("wrap_retired", 32'(retired_count), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $fatal(1);
  end

endmodule
